// File: rtl/bsk_prd_ctrl.sv
// bsk_prd_ctrl: command-input / indication controller for the BSK PRD board.
//
// Debounces N_CH discrete command inputs and drives N_CH active-low indication outputs.
// Also generates a gated test tone with a selectable frequency. The host reaches all of
// it through an asynchronous 16-bit rd/wr strobe bus. Everything else runs on clk.
//
// Ports:
//   clk        system clock
//   aclr       asynchronous active-high reset
//   bD         host data bus; driven only while selected and rd_n is low
//   rd_n       host read strobe, active low, asynchronous
//   wr_n       host write strobe, active low, asynchronous
//   a          host register address
//   cs_in      chip-select code, compared against CS
//   bl_n       block input, active low; forces test low
//   com_in     raw command inputs, active high
//   com_ind_n  indication outputs, active low, registered
//   cs_n_out   low while cs_in matches CS (combinational)
//   test       gated test tone
//
// Register map (16-bit):
//   0-3  debounced input groups, each byte {~nib, nib}
//   4    indication channels 15..0
//   5    indication channels 31..16 (reads 0 when N_CH=16)
//   6    control: bit0 test_en, bits2:1 freq_sel
//   7    ID: {PASSWORD, VERSION, test_en}
module bsk_prd_ctrl #(
  parameter int unsigned N_CH     = 16,
  parameter logic [6:0]  VERSION  = 7'h26,
  parameter logic [7:0]  PASSWORD = 8'hA4,
  parameter logic [3:0]  CS       = 4'b1011,
  parameter int unsigned DEB_CYC  = 20,
  parameter int unsigned TEST_DIV = 4
) (
  input  logic            clk,
  input  logic            aclr,
  inout  wire  [15:0]     bD,
  input  logic            rd_n,
  input  logic            wr_n,
  input  logic [2:0]      a,
  input  logic [3:0]      cs_in,
  input  logic            bl_n,
  input  logic [N_CH-1:0] com_in,
  output logic [N_CH-1:0] com_ind_n,
  output logic            cs_n_out,
  output logic            test
);

  localparam int unsigned DebW = $clog2(DEB_CYC);
  localparam int unsigned DivW = $clog2(TEST_DIV * 8);

  // Selection and bus drive
  logic        sel;
  logic [15:0] rd_data_q;

  assign sel      = (cs_in == CS);
  assign cs_n_out = ~sel;
  assign bD       = (sel && !rd_n) ? rd_data_q : 16'hzzzz;

  // Strobe synchronisers and bus holding pipeline. The strobe chains reset to 0 (active),
  // so a strobe already in progress at reset release produces no falling edge. That lets
  // its rising edge be discarded. The data/address pipe is two deep so that it lines up
  // with the synchronised strobes.
  logic        rd_s1, rd_s2, rd_s3;
  logic        wr_s1, wr_s2, wr_s3;
  logic [15:0] bd_q1, bd_q2;
  logic [2:0]  a_q1, a_q2;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rd_s1 <= 1'b0;
      rd_s2 <= 1'b0;
      rd_s3 <= 1'b0;
      wr_s1 <= 1'b0;
      wr_s2 <= 1'b0;
      wr_s3 <= 1'b0;
      bd_q1 <= '0;
      bd_q2 <= '0;
      a_q1  <= '0;
      a_q2  <= '0;
    end else begin
      rd_s1 <= rd_n;
      rd_s2 <= rd_s1;
      rd_s3 <= rd_s2;
      wr_s1 <= wr_n;
      wr_s2 <= wr_s1;
      wr_s3 <= wr_s2;
      bd_q1 <= bD;
      bd_q2 <= bd_q1;
      a_q1  <= a;
      a_q2  <= a_q1;
    end
  end

  logic rd_fall, wr_fall, wr_rise;

  assign rd_fall = rd_s3 & ~rd_s2;
  assign wr_fall = wr_s3 & ~wr_s2;
  assign wr_rise = ~wr_s3 & wr_s2;

  // Write capture. wr_arm is set by a seen falling edge. It is dropped if a read overlaps
  // the write, so the read wins and the write is lost.
  logic        wr_arm_q;
  logic [15:0] wr_bd_q;
  logic [2:0]  wr_a_q;
  logic        wr_go;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_arm_q <= 1'b0;
      wr_bd_q  <= '0;
      wr_a_q   <= '0;
    end else begin
      if (!rd_s2 && !wr_s2) begin
        wr_arm_q <= 1'b0;
      end else if (wr_fall) begin
        wr_arm_q <= 1'b1;
      end else if (wr_rise) begin
        wr_arm_q <= 1'b0;
      end
      if (!wr_s2) begin
        wr_bd_q <= bd_q2;
        wr_a_q  <= a_q2;
      end
    end
  end

  assign wr_go = wr_rise & wr_arm_q & sel;

  // Debounce: 2-FF sync, then a counter that runs only while the synced input differs
  // from the debounced value.
  logic [N_CH-1:0] com_s1, com_s2, deb_q;
  logic [DebW-1:0] deb_cnt_q [N_CH];

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      com_s1 <= '0;
      com_s2 <= '0;
      deb_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt_q[i] <= '0;
      end
    end else begin
      com_s1 <= com_in;
      com_s2 <= com_s1;
      for (int i = 0; i < N_CH; i++) begin
        if (com_s2[i] == deb_q[i]) begin
          deb_cnt_q[i] <= '0;
        end else if (deb_cnt_q[i] == DebW'(DEB_CYC - 1)) begin
          deb_q[i]     <= ~deb_q[i];
          deb_cnt_q[i] <= '0;
        end else begin
          deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Indication and control registers
  logic [N_CH-1:0] ind_q;
  logic            test_en_q;
  logic [1:0]      freq_sel_q;
  logic            ctrl_chg;

  assign ctrl_chg = wr_go && (wr_a_q == 3'd6) &&
                    ((wr_bd_q[0] != test_en_q) || (wr_bd_q[2:1] != freq_sel_q));

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ind_q      <= '0;
      test_en_q  <= 1'b0;
      freq_sel_q <= '0;
      com_ind_n  <= '1;
    end else begin
      if (wr_go) begin
        case (wr_a_q)
          3'd4: ind_q[15:0] <= wr_bd_q;
          3'd5: begin
            // Empty loop when N_CH=16, so the write is dropped.
            for (int i = 16; i < N_CH; i++) begin
              ind_q[i] <= wr_bd_q[i-16];
            end
          end
          3'd6: begin
            test_en_q  <= wr_bd_q[0];
            freq_sel_q <= wr_bd_q[2:1];
          end
          default: ;
        endcase
      end
      com_ind_n <= ~ind_q;
    end
  end

  // Read mux, latched on the synchronised rd_n falling edge
  logic [31:0] deb32, ind32;
  logic [15:0] grp_word [4];
  logic [3:0]  nib;
  logic [15:0] rd_mux;

  assign deb32 = 32'(deb_q);
  assign ind32 = 32'(ind_q);

  always_comb begin
    nib = '0;
    for (int k = 0; k < 4; k++) begin
      grp_word[k] = '0;
      for (int j = 0; j < 2; j++) begin
        nib = deb32[8*k+4*j +: 4];
        grp_word[k][8*j +: 8] = {~nib, nib};
      end
      if (8 * k >= N_CH) begin
        grp_word[k] = '0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (a_q2)
      3'd0:    rd_mux = grp_word[0];
      3'd1:    rd_mux = grp_word[1];
      3'd2:    rd_mux = grp_word[2];
      3'd3:    rd_mux = grp_word[3];
      3'd4:    rd_mux = ind32[15:0];
      3'd5:    rd_mux = ind32[31:16];
      3'd6:    rd_mux = {13'd0, freq_sel_q, test_en_q};
      default: rd_mux = {PASSWORD, VERSION, test_en_q};
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rd_data_q <= '0;
    end else if (rd_fall && sel) begin
      rd_data_q <= rd_mux;
    end
  end

  // Test tone: half-period TEST_DIV << freq_sel clocks
  logic [DivW-1:0] div_q;
  logic [DivW-1:0] half_m1;
  logic            tone_q;

  assign half_m1 = DivW'((TEST_DIV << freq_sel_q) - 1);

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      div_q  <= '0;
      tone_q <= 1'b0;
    end else if (!test_en_q || ctrl_chg) begin
      div_q  <= '0;
      tone_q <= 1'b0;
    end else if (div_q == half_m1) begin
      div_q  <= '0;
      tone_q <= ~tone_q;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign test = tone_q & test_en_q & bl_n;

endmodule
